// File: rtl/w_ptr_level_prog.sv
// w_ptr_level_prog: write-domain pointer/flag block for the async camera-data FIFO.
// Produces the binary RAM write address, the Gray write pointer for the read-side
// synchroniser, the full flag, a programmable almost-full flag and the fill level
// as seen from the write clock domain.
// Optional build macro: WPTR_OVF_STICKY_EN enables the sticky write-while-full flag.
module w_ptr_level_prog #(
  parameter int unsigned ADDR_SIZE  = 4,
  parameter int unsigned AF_DEFAULT = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [ADDR_SIZE:0]   w_syn_r_gray,
  input  logic [ADDR_SIZE:0]   w_af_thresh,
  input  logic                 w_af_load,
  input  logic                 w_ovf_clr,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_gray,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ADDR_SIZE:0]   w_level,
  output logic                 w_ovf
);

  localparam int unsigned PW    = ADDR_SIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  localparam logic [PW-1:0] THR_RST = (AF_DEFAULT > DEPTH) ? PW'(DEPTH) : PW'(AF_DEFAULT);

  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_gray;
  logic          r_full;
  logic          r_af;
  logic [PW-1:0] r_level;
  logic [PW-1:0] r_thr;

  logic          w_wr_ok;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_r_bin_s;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_free_next;
  logic [PW-1:0] w_full_gray;
  logic          w_full_val;
  logic          w_af_val;
  logic [PW-1:0] w_thr_clamped;

  // Next pointer, decoded read pointer and next-cycle flag values
  always_comb begin
    w_wr_ok     = w_inc & ~r_full;
    w_bin_next  = r_bin + PW'(w_wr_ok);
    w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
    w_r_bin_s   = '0;
    for (int i = 0; i < int'(PW); i++) begin
      w_r_bin_s[i] = ^(w_syn_r_gray >> i);
    end
    w_level_next  = w_bin_next - w_r_bin_s;
    w_free_next   = DEPTH_W - w_level_next;
    w_full_gray   = {~w_syn_r_gray[PW-1:PW-2], w_syn_r_gray[PW-3:0]};
    w_full_val    = (w_gray_next == w_full_gray);
    w_af_val      = (w_free_next <= r_thr);
    w_thr_clamped = (w_af_thresh > DEPTH_W) ? DEPTH_W : w_af_thresh;
  end

  // Pointer, level and flag registers; flags track the read pointer every cycle
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_full  <= w_full_val;
      r_af    <= w_af_val;
      r_level <= w_level_next;
    end
  end

  // Almost-full threshold; a load takes effect from the following edge
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_thr <= THR_RST;
    end else if (w_af_load) begin
      r_thr <= w_thr_clamped;
    end
  end

`ifdef WPTR_OVF_STICKY_EN
  logic r_ovf;

  // Sticky overflow: a write attempt while full sets it, set beats clear
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ovf <= 1'b0;
    end else if (w_inc & r_full) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_ovf = r_ovf;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = w_ovf_clr;
  assign w_ovf            = 1'b0;
`endif

  assign w_addr        = r_bin[ADDR_SIZE-1:0];
  assign w_gray        = r_gray;
  assign w_full        = r_full;
  assign w_almost_full = r_af;
  assign w_level       = r_level;

endmodule

// File: tb/tb_w_ptr_level_prog.sv
// Directed self-checking bench for w_ptr_level_prog (ADDR_SIZE=4, AF_DEFAULT=4).
module tb_w_ptr_level_prog;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;

`ifdef WPTR_OVF_STICKY_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic          w_clk;
  logic          w_rst;
  logic          w_inc;
  logic [PW-1:0] w_syn_r_gray;
  logic [PW-1:0] w_af_thresh;
  logic          w_af_load;
  logic          w_ovf_clr;
  logic [AW-1:0] w_addr;
  logic [PW-1:0] w_gray;
  logic          w_full;
  logic          w_almost_full;
  logic [PW-1:0] w_level;
  logic          w_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  w_ptr_level_prog #(.ADDR_SIZE(AW), .AF_DEFAULT(4)) dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .w_inc         (w_inc),
    .w_syn_r_gray  (w_syn_r_gray),
    .w_af_thresh   (w_af_thresh),
    .w_af_load     (w_af_load),
    .w_ovf_clr     (w_ovf_clr),
    .w_addr        (w_addr),
    .w_gray        (w_gray),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_ovf         (w_ovf)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge w_clk);
      #1;
    end
  endtask

  initial begin
    w_rst = 1'b1; w_inc = 1'b0; w_syn_r_gray = '0;
    w_af_thresh = '0; w_af_load = 1'b0; w_ovf_clr = 1'b0;
    step(2);

    // 1: reset values
    check("rst_addr",  32'(w_addr), 32'd0);
    check("rst_gray",  32'(w_gray), 32'd0);
    check("rst_full",  32'(w_full), 32'd0);
    check("rst_af",    32'(w_almost_full), 32'd0);
    check("rst_level", 32'(w_level), 32'd0);
    check("rst_ovf",   32'(w_ovf), 32'd0);
    w_rst = 1'b0;
    step(1);

    // 2: fill with read pointer at 0
    w_inc = 1'b1;
    step(11);
    check("fill11_level", 32'(w_level), 32'd11);
    check("fill11_af",    32'(w_almost_full), 32'd0);
    step(1);
    check("fill12_af",    32'(w_almost_full), 32'd1);
    step(3);
    check("fill15_full",  32'(w_full), 32'd0);
    step(1);
    check("fill16_full",  32'(w_full), 32'd1);
    check("fill16_level", 32'(w_level), 32'd16);
    check("fill16_gray",  32'(w_gray), 32'b11000);
    check("fill16_addr",  32'(w_addr), 32'd0);

    // 3: write while full is ignored, overflow flag
    step(1);
    check("ovf_addr", 32'(w_addr), 32'd0);
    check("ovf_gray", 32'(w_gray), 32'b11000);
    check("ovf_set",  32'(w_ovf), 32'(OVF_ON));
    w_inc = 1'b0; w_ovf_clr = 1'b1;
    step(1);
    check("ovf_clr",  32'(w_ovf), 32'd0);
    w_ovf_clr = 1'b0;

    // 4: read pointer to 16, then wrap write pointer 31 -> 0
    w_syn_r_gray = 5'b11000;
    step(1);
    check("drain_level", 32'(w_level), 32'd0);
    check("drain_full",  32'(w_full), 32'd0);
    check("drain_af",    32'(w_almost_full), 32'd0);
    w_inc = 1'b1;
    step(15);
    check("wrap31_level", 32'(w_level), 32'd15);
    check("wrap31_gray",  32'(w_gray), 32'b10000);
    check("wrap31_addr",  32'(w_addr), 32'd15);
    check("wrap31_full",  32'(w_full), 32'd0);
    check("wrap31_af",    32'(w_almost_full), 32'd1);
    step(1);
    check("wrap0_level", 32'(w_level), 32'd16);
    check("wrap0_full",  32'(w_full), 32'd1);
    check("wrap0_gray",  32'(w_gray), 32'd0);
    check("wrap0_addr",  32'(w_addr), 32'd0);

    // 5: threshold 0 -> almost-full follows full
    w_inc = 1'b0; w_af_load = 1'b1; w_af_thresh = 5'd0;
    step(1);
    w_af_load = 1'b0;
    w_syn_r_gray = 5'b11001;
    step(1);
    check("thr0_level", 32'(w_level), 32'd15);
    check("thr0_full",  32'(w_full), 32'd0);
    check("thr0_af",    32'(w_almost_full), 32'd0);
    w_inc = 1'b1;
    step(1);
    check("thr0w_full", 32'(w_full), 32'd1);
    check("thr0w_af",   32'(w_almost_full), 32'd1);
    check("thr0w_addr", 32'(w_addr), 32'd1);
    // load 20 (clamped to 16) at level 0: old threshold on the load edge
    w_inc = 1'b0; w_syn_r_gray = 5'b00001; w_af_load = 1'b1; w_af_thresh = 5'd20;
    step(1);
    check("ld20_level", 32'(w_level), 32'd0);
    check("ld20_old",   32'(w_almost_full), 32'd0);
    w_af_load = 1'b0;
    step(1);
    check("ld20_new",   32'(w_almost_full), 32'd1);
    // load 2 together with a write: that edge still uses threshold 16
    w_inc = 1'b1; w_af_load = 1'b1; w_af_thresh = 5'd2;
    step(1);
    check("ldw_level", 32'(w_level), 32'd1);
    check("ldw_af",    32'(w_almost_full), 32'd1);
    w_inc = 1'b0; w_af_load = 1'b0;
    step(1);
    check("ld2_af",    32'(w_almost_full), 32'd0);

    // 6: reset mid-burst at level 7
    w_inc = 1'b1;
    step(6);
    check("burst_level", 32'(w_level), 32'd7);
    w_rst = 1'b1;
    #1;
    check("mrst_addr",  32'(w_addr), 32'd0);
    check("mrst_gray",  32'(w_gray), 32'd0);
    check("mrst_level", 32'(w_level), 32'd0);
    check("mrst_full",  32'(w_full), 32'd0);
    check("mrst_af",    32'(w_almost_full), 32'd0);
    w_syn_r_gray = '0;
    step(1);
    w_rst = 1'b0;
    step(1);
    check("rel_addr",  32'(w_addr), 32'd1);
    check("rel_level", 32'(w_level), 32'd1);
    // threshold back to 4: almost-full asserts at level 12, not earlier
    step(10);
    check("rel11_af", 32'(w_almost_full), 32'd0);
    step(1);
    check("rel12_af", 32'(w_almost_full), 32'd1);
    w_inc = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
